// File: rtl/operand_fetch_stage_if.sv
// Bundle between the operand-fetch stage and its neighbours: the issue port from
// upstream, the operand port to the ALU, the writeback port from the ALU and the
// busy flag.
// The master side drives instructions, out_ready and writebacks.
// The slave side is the stage itself.
interface operand_fetch_stage_if #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned ADDR_W = 2
);
  logic              in_valid;
  logic              in_ready;
  logic [7:0]        in_instr;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] rs_data1;
  logic [DATA_W-1:0] rs_data2;
  logic [1:0]        alu_op;
  logic [ADDR_W-1:0] out_rd;
  logic              wb_en;
  logic [ADDR_W-1:0] wb_addr;
  logic [DATA_W-1:0] wb_data;
  logic              busy;

  modport master (
    output in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    input  in_ready, out_valid, rs_data1, rs_data2, alu_op, out_rd, busy
  );

  modport slave (
    input  in_valid, in_instr, out_ready, wb_en, wb_addr, wb_data,
    output in_ready, out_valid, rs_data1, rs_data2, alu_op, out_rd, busy
  );
endinterface

// File: rtl/operand_fetch_stage.sv
// Decode / operand-fetch stage ahead of the 8-bit ALU.
// Reads a small register file and registers the operands, op and destination
// tag toward the ALU. A per-register pending scoreboard stalls RAW/WAW hazards
// until the matching writeback arrives.
// Optional macro OPERAND_BYPASS_EN: a same-cycle writeback releases its pending
// bit at once, and wb_data is forwarded into the operand read.
module operand_fetch_stage #(
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  operand_fetch_stage_if.slave   bus
);
  localparam int unsigned AddrW = 2;

  logic [DATA_W-1:0]   regs_q [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q, pending_d;

  logic                out_valid_q;
  logic [DATA_W-1:0]   rs_data1_q, rs_data2_q;
  logic [1:0]          alu_op_q;
  logic [AddrW-1:0]    out_rd_q;

  logic [AddrW-1:0]    rd, rs1, rs2;
  logic [NUM_REGS-1:0] wb_onehot, rd_onehot, pend_eff;
  logic [DATA_W-1:0]   src1, src2;
  logic                hz, in_ready, issue;

  // Decode fields, build the hazard check and select the operand sources
  always_comb begin
    rd        = bus.in_instr[5:4];
    rs1       = bus.in_instr[3:2];
    rs2       = bus.in_instr[1:0];
    wb_onehot = '0;
    rd_onehot = '0;
    if (bus.wb_en) wb_onehot[bus.wb_addr] = 1'b1;
    rd_onehot[rd] = 1'b1;
`ifdef OPERAND_BYPASS_EN
    pend_eff = pending_q & ~wb_onehot;
    src1     = (bus.wb_en && bus.wb_addr == rs1) ? bus.wb_data : regs_q[rs1];
    src2     = (bus.wb_en && bus.wb_addr == rs2) ? bus.wb_data : regs_q[rs2];
`else
    pend_eff = pending_q;
    src1     = regs_q[rs1];
    src2     = regs_q[rs2];
`endif
    hz        = pend_eff[rs1] | pend_eff[rs2] | pend_eff[rd];
    in_ready  = !hz && (!out_valid_q || bus.out_ready);
    issue     = bus.in_valid && in_ready;
    // A writeback clears its bit, but an issue to the same rd sets it again
    pending_d = (pending_q & ~wb_onehot) | (issue ? rd_onehot : '0);
  end

  // Register file write port
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else if (bus.wb_en) begin
      regs_q[bus.wb_addr] <= bus.wb_data;
    end
  end

  // Scoreboard of registers awaiting writeback
  always_ff @(posedge clk) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

  // Output pipeline register toward the ALU; data fields hold when drained
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      rs_data1_q  <= '0;
      rs_data2_q  <= '0;
      alu_op_q    <= '0;
      out_rd_q    <= '0;
    end else if (issue) begin
      out_valid_q <= 1'b1;
      rs_data1_q  <= src1;
      rs_data2_q  <= src2;
      alu_op_q    <= bus.in_instr[7:6];
      out_rd_q    <= rd;
    end else if (bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  // Drive the interface outputs
  always_comb begin
    bus.in_ready  = in_ready;
    bus.out_valid = out_valid_q;
    bus.rs_data1  = rs_data1_q;
    bus.rs_data2  = rs_data2_q;
    bus.alu_op    = alu_op_q;
    bus.out_rd    = out_rd_q;
    bus.busy      = |pending_q;
  end
endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage. Inputs change just after the falling
// edge and outputs are sampled there, away from the rising edge. Expectations
// follow the OPERAND_BYPASS_EN setting of the build.
module tb_operand_fetch_stage;
  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  operand_fetch_stage_if #(.DATA_W(8), .ADDR_W(2)) bus ();

  operand_fetch_stage #(.DATA_W(8), .NUM_REGS(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and return at the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check_out(input string tag, input logic v, input logic [7:0] d1,
                           input logic [7:0] d2, input logic [1:0] op, input logic [1:0] rd);
    check({tag, ".out_valid"}, 32'(bus.out_valid), 32'(v));
    check({tag, ".rs_data1"},  32'(bus.rs_data1),  32'(d1));
    check({tag, ".rs_data2"},  32'(bus.rs_data2),  32'(d2));
    check({tag, ".alu_op"},    32'(bus.alu_op),    32'(op));
    check({tag, ".out_rd"},    32'(bus.out_rd),    32'(rd));
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_instr = '0;
    bus.out_ready = 1'b0;
    bus.wb_en    = 1'b0;
    bus.wb_addr  = '0;
    bus.wb_data  = '0;
    @(negedge clk);
    step();
    step();
    check_out("reset", 1'b0, 8'h00, 8'h00, 2'd0, 2'd0);
    check("reset.busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1;

    // Test 1: preload R1, R2 then issue ADD r3 <- r1, r2
    bus.wb_en = 1'b1; bus.wb_addr = 2'd1; bus.wb_data = 8'h0A;
    step();
    bus.wb_addr = 2'd2; bus.wb_data = 8'h05;
    step();
    bus.wb_en = 1'b0;
    bus.in_valid = 1'b1; bus.in_instr = 8'b00_11_01_10; bus.out_ready = 1'b1;
    #1 check("t1.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check_out("t1", 1'b1, 8'h0A, 8'h05, 2'd0, 2'd3);
    check("t1.busy", 32'(bus.busy), 32'd1);

    // Test 2: backpressure freezes outputs and blocks an independent instr
    bus.in_instr = 8'b11_00_01_10; bus.out_ready = 1'b0;
    #1 check("t2.in_ready_bp", 32'(bus.in_ready), 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_out("t2.frozen", 1'b1, 8'h0A, 8'h05, 2'd0, 2'd3);
    end
    bus.out_ready = 1'b1;
    #1 check("t2.in_ready_go", 32'(bus.in_ready), 32'd1);
    step();
    check_out("t2.second", 1'b1, 8'h0A, 8'h05, 2'd3, 2'd0);
    bus.in_valid = 1'b0;

    // Release R0 so only R3 stays pending; outputs drain
    bus.wb_en = 1'b1; bus.wb_addr = 2'd0; bus.wb_data = 8'h77;
    step();
    bus.wb_en = 1'b0;
    check("t3.drained", 32'(bus.out_valid), 32'd0);
    check("t3.busy", 32'(bus.busy), 32'd1);

    // Test 3: RAW on R3, SUB r0 <- r3, r1
    bus.in_valid = 1'b1; bus.in_instr = 8'b01_00_11_01;
    #1 check("t3.stall0", 32'(bus.in_ready), 32'd0);
    step();
    check("t3.stall1", 32'(bus.in_ready), 32'd0);
    bus.wb_en = 1'b1; bus.wb_addr = 2'd3; bus.wb_data = 8'h0F;
`ifdef OPERAND_BYPASS_EN
    #1 check("t3.release", 32'(bus.in_ready), 32'd1);
    step();
    bus.wb_en = 1'b0;
`else
    #1 check("t3.release", 32'(bus.in_ready), 32'd0);
    step();
    bus.wb_en = 1'b0;
    #1 check("t3.release_next", 32'(bus.in_ready), 32'd1);
    step();
`endif
    check_out("t3", 1'b1, 8'h0F, 8'h0A, 2'd1, 2'd0);

    // Test 4: WAW on R2. Set R2 pending while releasing R0.
    bus.in_instr = 8'b00_10_01_01;
    bus.wb_en = 1'b1; bus.wb_addr = 2'd0; bus.wb_data = 8'h11;
    #1 check("t4.in_ready_set", 32'(bus.in_ready), 32'd1);
    step();
    check_out("t4.set", 1'b1, 8'h0A, 8'h0A, 2'd0, 2'd2);
    bus.wb_en = 1'b0;
    bus.in_instr = 8'b10_10_01_11;
    #1 check("t4.waw_stall0", 32'(bus.in_ready), 32'd0);
    step();
    check("t4.waw_stall1", 32'(bus.in_ready), 32'd0);
    bus.wb_en = 1'b1; bus.wb_addr = 2'd2; bus.wb_data = 8'h22;
`ifdef OPERAND_BYPASS_EN
    #1 check("t4.release", 32'(bus.in_ready), 32'd1);
    step();
`else
    #1 check("t4.release", 32'(bus.in_ready), 32'd0);
    step();
    // R2 now free: writeback and issue to R2 together
    #1 check("t4.release_next", 32'(bus.in_ready), 32'd1);
    step();
`endif
    bus.wb_en = 1'b0;
    check_out("t4", 1'b1, 8'h0A, 8'h0F, 2'd2, 2'd2);
    check("t4.busy", 32'(bus.busy), 32'd1);
    bus.in_instr = 8'b00_01_10_00;
    #1 check("t4.pend2_set", 32'(bus.in_ready), 32'd0);
    bus.in_valid = 1'b0;
    bus.wb_en = 1'b1; bus.wb_addr = 2'd2; bus.wb_data = 8'h44;
    step();
    bus.wb_en = 1'b0;
    check("t4.busy_clear", 32'(bus.busy), 32'd0);

    // Test 5: writeback to non-pending R1 alongside a read of R1
    bus.in_valid = 1'b1; bus.in_instr = 8'b00_00_01_00;
    bus.wb_en = 1'b1; bus.wb_addr = 2'd1; bus.wb_data = 8'h33;
    #1 check("t5.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    bus.wb_en = 1'b0;
`ifdef OPERAND_BYPASS_EN
    check_out("t5.same", 1'b1, 8'h33, 8'h11, 2'd0, 2'd0);
`else
    check_out("t5.same", 1'b1, 8'h0A, 8'h11, 2'd0, 2'd0);
`endif
    bus.in_instr = 8'b00_11_01_01;
    step();
    check_out("t5.after", 1'b1, 8'h33, 8'h33, 2'd0, 2'd3);

    // Test 6: reset while R0/R3 pending, output held and an instr stalled
    bus.in_instr = 8'b00_01_11_00; bus.out_ready = 1'b0;
    bus.wb_en = 1'b1; bus.wb_addr = 2'd2; bus.wb_data = 8'h99;
    rst_n = 1'b0;
    step();
    bus.wb_en = 1'b0;
    check_out("t6.reset", 1'b0, 8'h00, 8'h00, 2'd0, 2'd0);
    check("t6.busy", 32'(bus.busy), 32'd0);
    rst_n = 1'b1; bus.out_ready = 1'b1;
    bus.in_instr = 8'b11_00_00_01;
    #1 check("t6.in_ready", 32'(bus.in_ready), 32'd1);
    step();
    check_out("t6.r0r1", 1'b1, 8'h00, 8'h00, 2'd3, 2'd0);
    bus.in_instr = 8'b00_01_10_11;
    step();
    check_out("t6.r2r3", 1'b1, 8'h00, 8'h00, 2'd0, 2'd1);
    bus.in_valid = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode/operand-fetch stage directly upstream of the 8-bit ALU.
- Accepts 8-bit instructions, reads a 4x8 register file and presents rs_data1, rs_data2 and alu_op to the ALU through an output pipeline register.
- Accepts ALU results back through a writeback port.
- A per-register pending scoreboard stalls RAW/WAW hazards.

Parameters:
DATA_W, 8, register and operand width
NUM_REGS, 4, register count (address width = 2)

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  instruction valid
in_ready  output  1  stage accepts instruction this cycle
in_instr  input  8  [7:6] alu_op, [5:4] rd, [3:2] rs1, [1:0] rs2
out_valid  output  1  operands valid to ALU
out_ready  input  1  ALU consumes operands
rs_data1  output  8  operand 1 (ALU rs_data1)
rs_data2  output  8  operand 2 (ALU rs_data2)
alu_op  output  2  00 ADD, 01 SUB, 10 SLL, 11 AND; passed through unchanged
out_rd  output  2  destination register tag travelling with operands
wb_en  input  1  writeback strobe
wb_addr  input  2  writeback register
wb_data  input  8  writeback value (ALU result)
busy  output  1  OR of all pending bits

Behaviour:
- Reset (rst_n=0 at posedge clk):
  - out_valid, rs_data1, rs_data2, alu_op, out_rd, pending[3:0] and all registers go to 0.
  - Reset wins over any simultaneous issue or writeback, including mid-stall.
- Hazard: hz = pend_eff[rs1] | pend_eff[rs2] | pend_eff[rd], where pend_eff = pending (see the optional feature for bypass).
- in_ready = !hz && (!out_valid || out_ready). This is combinational from in_instr, pending and out state.
- Issue when in_valid && in_ready. At the next edge:
  - out_valid <= 1.
  - rs_data1 <= R[rs1], rs_data2 <= R[rs2].
  - alu_op <= instr[7:6], out_rd <= rd.
  - pending[rd] <= 1.
- Latency: instruction accepted at edge N, operands visible after edge N (one cycle).
- Output register:
  - out_valid && !out_ready: all out_* fields hold stable.
  - out_valid && out_ready && no issue: out_valid <= 0 and data fields hold their last values.
  - Consume and issue in the same cycle: new operands load and out_valid stays 1.
- Writeback, wb_en=1:
  - R[wb_addr] <= wb_data and pending[wb_addr] <= 0.
  - Writeback to a non-pending register is legal: the register is written and pending is unchanged.
- Same-cycle issue with rd == wb_addr: the set wins, so pending[rd] = 1.
- Same-cycle writeback and issue reading wb_addr when that register is not pending: without bypass the old value is read; with bypass, wb_data is read.
- Without BYPASS_EN, wb_data written at edge N is readable by an issue at edge N+1.
- No arithmetic is performed here; data widths are DATA_W, with no extension or truncation.
- in_valid with in_ready=0: the instruction is not consumed. Upstream holds in_instr stable.

Optional Feature:
Macro OPERAND_BYPASS_EN.
- Defined:
  - pend_eff = pending & ~(wb_en ? onehot(wb_addr) : 0).
  - Any source read whose address equals wb_addr with wb_en=1 takes wb_data instead of R[].
  - A stalled instruction therefore issues in the same cycle as its releasing writeback.
- Undefined:
  - pend_eff = pending and there is no forwarding.
  - A stalled instruction issues in the cycle after the writeback edge and reads the register-file value.

Test Plan:
1. Preload R1=0x0A, R2=0x05 via wb_en, with in_valid=0. Then in_instr=8'b00_11_01_10, out_ready=1 -> one cycle later out_valid=1, rs_data1=0x0A, rs_data2=0x05, alu_op=00, out_rd=3, busy=1.
2. Backpressure: hold out_ready=0 for 3 cycles with a second independent instr (8'b11_00_01_10) valid -> in_ready=0 and outputs frozen at test-1 values. Raise out_ready -> second instr loads the next edge: alu_op=11, out_rd=0.
3. RAW: R3 pending, in_instr=8'b01_00_11_01 -> in_ready=0. Then wb_en=1, wb_addr=3, wb_data=0x0F:
   - With bypass: issue in that cycle, rs_data1=0x0F, rs_data2=0x0A.
   - Without bypass: issue one cycle later with the same data.
4. WAW: R2 pending, instr with rd=2 and sources not pending -> stalled until wb to R2. Same-cycle wb/issue to R2 -> pending[2]=1 afterwards.
5. Same-cycle wb to non-pending R1 (wb_data=0x33) while issuing a read of R1 (old value 0x0A) -> rs_data1=0x33 with bypass, 0x0A without. R1=0x33 afterwards in both cases.
6. Reset mid-stall: R3 pending, out_valid=1, rst_n=0 for one edge -> out_valid=0, busy=0, all outputs 0, R0..R3 read back 0 on the next issue.
